// File: rtl/note_player.sv
// note_player: turns one note command into timed playback,
// counting beats down and stepping a phase accumulator per sample.
module note_player #(
   parameter int NOTE_W  = 6,
   parameter int DUR_W   = 6,
   parameter int PHASE_W = 22,
   parameter int STEP_W  = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               play_enable,
   input  logic               load_new_note,
   input  logic [NOTE_W-1:0]  note_to_load,
   input  logic [DUR_W-1:0]   duration_to_load,
   input  logic               beat,
   input  logic [STEP_W-1:0]  step_size,
   input  logic               generate_next_sample,
   output logic [NOTE_W-1:0]  note,
   output logic [PHASE_W-1:0] sample_phase,
   output logic               new_sample_ready,
   output logic               busy,
   output logic               done_with_note
);

   typedef enum logic [1:0] {
      IDLE,
      PLAY,
      DONE
   } state_t;

   state_t              state, state_n;
   logic [DUR_W-1:0]    cnt, cnt_n;
   logic [NOTE_W-1:0]   note_n;
   logic [PHASE_W-1:0]  phase_n;
   logic                accept_beat;
   logic                advance;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      note_n      = note;
      phase_n     = sample_phase;
      accept_beat = (state == PLAY) && play_enable && beat;
      advance     = (state == PLAY) && play_enable
                    && generate_next_sample && (note != '0);
      if (load_new_note) begin
         note_n  = note_to_load;
         cnt_n   = duration_to_load;
         phase_n = '0;
         state_n = (duration_to_load == '0) ? DONE : PLAY;
      end else begin
         if (advance)
            phase_n = sample_phase + PHASE_W'(step_size);
         unique case (state)
            IDLE: phase_n = '0;
            PLAY: begin
               if (accept_beat) begin
                  cnt_n = cnt - DUR_W'(1);
                  if (cnt == DUR_W'(1))
                     state_n = DONE;
               end
            end
            DONE: begin
               state_n = IDLE;
               phase_n = '0;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // busy/done are registered views of the state being entered
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= IDLE;
         cnt              <= '0;
         note             <= '0;
         sample_phase     <= '0;
         new_sample_ready <= 1'b0;
         busy             <= 1'b0;
         done_with_note   <= 1'b0;
      end else begin
         state            <= state_n;
         cnt              <= cnt_n;
         note             <= note_n;
         sample_phase     <= phase_n;
         new_sample_ready <= generate_next_sample & play_enable;
         busy             <= (state_n == PLAY);
         done_with_note   <= (state_n == DONE);
      end
   end

endmodule

// File: tb/tb_note_player.sv
// tb_note_player: scenario tasks plus a randomized run, all checked
// against a beats-remaining / phase-sum reference model.
module tb_note_player;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        ld = 1'b0;
   logic        beat = 1'b0;
   logic        gen = 1'b0;
   logic [5:0]  nt = '0;
   logic [5:0]  dur = '0;
   logic [19:0] step_size;
   logic [5:0]  note;
   logic [21:0] sample_phase;
   logic        nsr, busy, done;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [5:0]  m_note = '0;
   int          m_left = 0;
   bit          m_play = 0;
   longint      m_phase = 0;
   bit          e_busy = 0, e_done = 0, e_nsr = 0;

   always #5 clk = ~clk;

   function automatic logic [19:0] rom(input logic [5:0] n);
      return (n == 6'd63) ? 20'hFFFFF : {n, 14'h01a5};
   endfunction

   assign step_size = rom(note);

   note_player dut (
      .clk                  (clk),
      .rst                  (rst),
      .play_enable          (en),
      .load_new_note        (ld),
      .note_to_load         (nt),
      .duration_to_load     (dur),
      .beat                 (beat),
      .step_size            (step_size),
      .generate_next_sample (gen),
      .note                 (note),
      .sample_phase         (sample_phase),
      .new_sample_ready     (nsr),
      .busy                 (busy),
      .done_with_note       (done)
   );

   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_note = '0; m_left = 0; m_play = 0; m_phase = 0;
         e_busy = 0; e_done = 0; e_nsr = 0;
      end else begin
         e_nsr  = gen && en;
         e_done = 0;
         if (ld) begin
            m_note  = nt;
            m_left  = int'(dur);
            m_phase = 0;
            m_play  = (dur != 0);
            e_done  = (dur == 0);
         end else if (m_play) begin
            if (en && gen && m_note != 0)
               m_phase = (m_phase + longint'(rom(m_note))) % (64'd1 << 22);
            if (en && beat) begin
               m_left--;
               if (m_left == 0) begin
                  m_play = 0;
                  e_done = 1;
               end
            end
         end else begin
            m_phase = 0;
         end
         e_busy = m_play;
      end
      #1;
      ld   = 1'b0;
      beat = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; ld = 1'b1; nt = 6'd9; dur = 6'd3;
      gen = 1'b1; en = 1'b1; beat = 1'b1;
      tick();
      tick();
      checks++;
      if (note !== 6'd0 || sample_phase !== 22'd0 || nsr !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset: note=%0d phase=%h nsr=%b busy=%b done=%b, want all 0",
                  note, sample_phase, nsr, busy, done);
      end
      rst = 1'b0; gen = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int dones = 0;
      en = 1'b1; gen = 1'b0;
      nt = 6'd10; dur = 6'd3; ld = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || note !== 6'd10) begin
         errors++;
         $display("FAIL basic_load: busy=%b note=%0d, want 1 10", busy, note);
      end
      for (int b = 1; b <= 3; b++) begin
         for (int i = 0; i < 9; i++) begin
            tick();
            if (done) dones++;
         end
         beat = 1'b1;
         tick();
         if (done) dones++;
         checks++;
         if (done !== (b == 3) || busy !== (b != 3)) begin
            errors++;
            $display("FAIL basic_beat%0d: done=%b busy=%b, want %b %b",
                     b, done, busy, b == 3, b != 3);
         end
      end
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || dones != 1) begin
         errors++;
         $display("FAIL basic_end: done=%b busy=%b pulses=%0d, want 0 0 1",
                  done, busy, dones);
      end
   endtask

   task automatic test_pause();
      logic [21:0] frozen;
      en = 1'b1; gen = 1'b1;
      nt = 6'd5; dur = 6'd4; ld = 1'b1;
      tick();
      for (int b = 1; b <= 6; b++) begin
         en = !(b == 2 || b == 3);
         frozen = sample_phase;
         for (int i = 0; i < 3; i++) tick();
         beat = 1'b1;
         tick();
         checks++;
         if (!en && sample_phase !== frozen) begin
            errors++;
            $display("FAIL pause_frozen: phase=%h, want %h", sample_phase, frozen);
         end
         checks++;
         if (done !== (b == 6) || sample_phase !== m_phase[21:0]) begin
            errors++;
            $display("FAIL pause_beat%0d: done=%b phase=%h, want %b %h",
                     b, done, sample_phase, b == 6, m_phase[21:0]);
         end
      end
      en = 1'b1; gen = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      logic [21:0] seq [6];
      seq = '{22'h000000, 22'h0FFFFF, 22'h1FFFFE,
              22'h2FFFFD, 22'h3FFFFC, 22'h0FFFFB};
      en = 1'b1; gen = 1'b1;
      nt = 6'd63; dur = 6'd40; ld = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (sample_phase !== seq[i] || nsr !== 1'b1) begin
            errors++;
            $display("FAIL wrap%0d: phase=%h nsr=%b, want %h 1",
                     i, sample_phase, nsr, seq[i]);
         end
         tick();
      end
      nt = 6'd0; ld = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sample_phase !== 22'd0 || nsr !== 1'b1) begin
            errors++;
            $display("FAIL rest%0d: phase=%h nsr=%b, want 0 1", i, sample_phase, nsr);
         end
         tick();
      end
      gen = 1'b0;
      tick();
      checks++;
      if (nsr !== 1'b0) begin
         errors++;
         $display("FAIL rest_nsr_off: nsr=%b, want 0", nsr);
      end
   endtask

   task automatic test_done_load();
      en = 1'b1; gen = 1'b0;
      nt = 6'd7; dur = 6'd1; ld = 1'b1;
      tick();
      beat = 1'b1;
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL doneload_pulse: done=%b busy=%b, want 1 0", done, busy);
      end
      nt = 6'd9; dur = 6'd2; ld = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || note !== 6'd9 || done !== 1'b0) begin
         errors++;
         $display("FAIL doneload_new: busy=%b note=%0d done=%b, want 1 9 0",
                  busy, note, done);
      end
      beat = 1'b1; tick();
      beat = 1'b1; tick();
      checks++;
      if (done !== 1'b1) begin
         errors++;
         $display("FAIL doneload_end: done=%b, want 1", done);
      end
      tick();
   endtask

   task automatic test_load_beat();
      en = 1'b1;
      nt = 6'd3; dur = 6'd5; ld = 1'b1;
      tick();
      nt = 6'd4; dur = 6'd2; ld = 1'b1; beat = 1'b1;
      tick();
      beat = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL loadbeat_mid: busy=%b done=%b, want 1 0", busy, done);
      end
      beat = 1'b1;
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL loadbeat_end: done=%b busy=%b, want 1 0", done, busy);
      end
      tick();
   endtask

   task automatic test_zero();
      nt = 6'd4; dur = 6'd0; ld = 1'b1;
      tick();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_dur: done=%b busy=%b, want 1 0", done, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_after: done=%b, want 0", done);
      end
   endtask

   task automatic test_reset_mid();
      int dones = 0;
      en = 1'b1; gen = 1'b1;
      nt = 6'd12; dur = 6'd5; ld = 1'b1;
      tick();
      beat = 1'b1; tick();
      tick();
      beat = 1'b1; tick();
      rst = 1'b1;
      tick();
      checks++;
      if (note !== 6'd0 || sample_phase !== 22'd0 || nsr !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL resetmid: note=%0d phase=%h nsr=%b busy=%b done=%b, want all 0",
                  note, sample_phase, nsr, busy, done);
      end
      rst = 1'b0; gen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         beat = 1'b1;
         tick();
         if (done) dones++;
      end
      checks++;
      if (dones != 0) begin
         errors++;
         $display("FAIL resetmid_nodone: pulses=%0d, want 0", dones);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 3000; c++) begin
         rst  = ($urandom_range(0, 199) == 0);
         en   = ($urandom_range(0, 9) < 8);
         ld   = ($urandom_range(0, 29) == 0);
         beat = ($urandom_range(0, 3) == 0);
         gen  = $urandom_range(0, 1);
         case ($urandom_range(0, 3))
            0: nt = 6'd0;
            1: nt = 6'd63;
            default: nt = 6'($urandom);
         endcase
         dur = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
         tick();
         checks++;
         if (note !== m_note || sample_phase !== m_phase[21:0] ||
             nsr !== e_nsr || busy !== e_busy || done !== e_done) begin
            errors++;
            $display("FAIL random@%0d: note=%0d phase=%h nsr=%b busy=%b done=%b, want %0d %h %b %b %b",
                     c, note, sample_phase, nsr, busy, done,
                     m_note, m_phase[21:0], e_nsr, e_busy, e_done);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_pause();
      test_wrap();
      test_done_load();
      test_load_beat();
      test_zero();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/note_player.md
# note_player

Consumes the one-cycle `beat` pulse from the beat generator and turns one note command (pitch code + duration in beats) into timed playback. Counts down the note's duration on accepted beats. Advances a phase accumulator for the downstream sample reader on every sample request. Reports completion to the song sequencer with `done_with_note`. Pitch-to-step translation happens in the external frequency ROM: this block presents `note` and receives `step_size` back combinationally.

## Interface
- `NOTE_W`, 6: pitch code width; code 0 is a rest.
- `DUR_W`, 6: duration width, in beats.
- `PHASE_W`, 22: phase accumulator width (10 fractional bits).
- `STEP_W`, 20: width of the `step_size` input from the frequency ROM.

Ports:
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `play_enable` input 1: 1 = run, 0 = pause (all counters frozen).
- `load_new_note` input 1: one-cycle strobe; latches the note command.
- `note_to_load` input NOTE_W: pitch code of the new note.
- `duration_to_load` input DUR_W: note length in beats.
- `beat` input 1: one-cycle pulse from the beat generator.
- `step_size` input STEP_W: phase increment for the current `note`, from the ROM.
- `generate_next_sample` input 1: one-cycle sample request from the codec side.
- `note` output NOTE_W: latched pitch code; drives the ROM address.
- `sample_phase` output PHASE_W: current phase accumulator value.
- `new_sample_ready` output 1: one-cycle pulse; `sample_phase` has been updated.
- `busy` output 1: high while the state is PLAY.
- `done_with_note` output 1: one-cycle completion pulse.

## Operation
- FSM states are IDLE, PLAY and DONE. All outputs are registered.
- On `rst`, regardless of any other input:
  - state = IDLE;
  - `note` = 0, the duration counter = 0, `sample_phase` = 0;
  - `new_sample_ready` = 0, `busy` = 0, `done_with_note` = 0.
- A `load_new_note` strobe is accepted in any state and has top priority over everything except `rst`. On acceptance:
  - latch `note_to_load` and `duration_to_load`;
  - clear `sample_phase` to 0;
  - next state is PLAY, or DONE if `duration_to_load` is 0.
  - `load_new_note` is not gated by `play_enable`.
- In PLAY, with `play_enable` = 1 and `beat` = 1 and no load:
  - the counter decrements;
  - if the counter was 1, the next state is DONE.
- Beats arriving while `play_enable` = 0, or outside PLAY, are ignored. They are not queued.
- DONE lasts exactly one cycle, with `done_with_note` = 1. The next state is IDLE, or PLAY if a load arrives in the DONE cycle.
- A load arriving in the DONE cycle does not suppress that cycle's `done_with_note` pulse.
- Phase accumulator: when `generate_next_sample` = 1, `play_enable` = 1 and the state is PLAY:
  - `sample_phase` <= `sample_phase` + zero-extended `step_size`, modulo 2^PHASE_W (it wraps silently);
  - if `note` = 0 (rest), `sample_phase` holds instead.
- `sample_phase` holds its value while paused. It is cleared to 0 on entry to IDLE.
- `new_sample_ready` is the registered value of (`generate_next_sample` & `play_enable`), in every state, so the codec keeps being fed samples during rests and idle periods.
- If `generate_next_sample` and `load_new_note` occur in the same cycle, the load wins: `sample_phase` becomes 0 and `new_sample_ready` still pulses.
- If `beat` and `generate_next_sample` occur in the same cycle, both take effect independently.

## Timing
- Load latency: a load sampled at edge t gives `note`, `busy` and the cleared phase valid after t, i.e. in cycle t+1.
- Note length: for duration N ≥ 1, if the Nth accepted beat is sampled at edge k, `done_with_note` is high for exactly the cycle following k, and `busy` falls at k.
- A zero duration yields `done_with_note` in the cycle immediately after the load cycle, with no beats consumed.
- Sample latency: a request sampled at edge t gives an updated `sample_phase` and `new_sample_ready` = 1 in cycle t+1. Back-to-back requests are supported at 1 per cycle.
- `step_size` is sampled in the same cycle as the request; the ROM must be combinational from `note`.
- `rst` asserted mid-note takes effect at the next edge: no `done_with_note` pulse is produced.

## Test plan
- Reset, then load note = 10, duration = 3 with `play_enable` = 1 and a beat every 10 cycles:
  - `busy` = 1 the next cycle;
  - `done_with_note` pulses exactly once, the cycle after the 3rd beat;
  - then IDLE with `busy` = 0.
- Pause mid-note: duration = 4, drop `play_enable` for 2 of the beats:
  - those 2 beats are ignored and `sample_phase` is frozen;
  - done arrives after 4 accepted beats.
- Phase wrap:
  - `step_size` = 20'hFFFFF with `generate_next_sample` every cycle; phase sequence is 0, 0x0FFFFF, 0x1FFFFE, 0x2FFFFD, 0x3FFFFC, 0x0FFFFB;
  - `new_sample_ready` is high in every cycle following a request;
  - with note = 0, phase stays 0 while `new_sample_ready` still pulses.
- Simultaneous events:
  - load during the DONE cycle: done still pulses and the new note plays;
  - load together with a beat: the counter takes the new duration with no decrement;
  - duration = 0: done in the cycle after the load.
- Reset mid-note (duration = 5, after 2 beats):
  - all outputs are 0 the next cycle;
  - no `done_with_note` ever appears for that note.
